// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one uart_tx among N_REQ byte producers, with frame and gap timing.
// Optional build macro UART_TX_SCHED_FIXED_PRIO_EN selects fixed lowest-index priority instead.
module uart_tx_sched #(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned FRAME_TICKS = 160,
  parameter int unsigned GAP_TICKS   = 16,
  localparam int unsigned GW         = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic [N_REQ-1:0]     req,
  input  logic [8*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]     ack,
  output logic                 tx_en,
  output logic [7:0]           tx_data,
  output logic [GW-1:0]        grant_id,
  output logic                 busy
);

  localparam int unsigned MAXT       = (FRAME_TICKS > GAP_TICKS) ? FRAME_TICKS : GAP_TICKS;
  localparam int unsigned CW         = $clog2(MAXT + 1);
  localparam int unsigned FRAME_LAST = FRAME_TICKS - 1;
  localparam int unsigned GAP_LAST   = (GAP_TICKS == 0) ? 0 : GAP_TICKS - 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CW-1:0]      r_cnt;
  logic [CW-1:0]      w_cnt_nxt;
  logic               w_grant;
  logic               w_found;
  logic [GW-1:0]      w_win;
  logic [N_REQ-1:0]   r_ack;
  logic               r_tx_en;
  logic [7:0]         r_tx_data;
  logic [GW-1:0]      r_grant_id;
  logic               r_busy;

`ifdef UART_TX_SCHED_FIXED_PRIO_EN
  // Lowest-index requester always wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[GW'(k)]) begin
        w_found = 1'b1;
        w_win   = GW'(k);
      end
    end
  end
`else
  logic [GW-1:0]      r_ptr;
  logic [GW-1:0]      w_cand;

  // First set request at or after the pointer, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_cand  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_cand = GW'((32'(r_ptr) + 32'(k)) % N_REQ);
      if (!w_found && req[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_grant) begin
      r_ptr <= (w_win == GW'(N_REQ - 1)) ? '0 : w_win + GW'(1);
    end
  end
`endif

  // Next-state and tick counting.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_grant     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_grant     = 1'b1;
          w_state_nxt = S_SEND;
          w_cnt_nxt   = '0;
        end
      end
      S_SEND: begin
        if (baud_tick) begin
          if (r_cnt == CW'(FRAME_LAST)) begin
            w_cnt_nxt   = '0;
            w_state_nxt = (GAP_TICKS == 0) ? S_IDLE : S_GAP;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
      end
      S_GAP: begin
        if (baud_tick) begin
          if (r_cnt == CW'(GAP_LAST)) begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_IDLE;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_ack      <= '0;
      r_tx_en    <= 1'b0;
      r_tx_data  <= '0;
      r_grant_id <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      r_tx_en <= w_grant;
      r_ack   <= w_grant ? (N_REQ'(1) << w_win) : '0;
      if (w_grant) begin
        r_tx_data  <= req_data[{w_win, 3'b000} +: 8];
        r_grant_id <= w_win;
      end
    end
  end

  assign ack      = r_ack;
  assign tx_en    = r_tx_en;
  assign tx_data  = r_tx_data;
  assign grant_id = r_grant_id;
  assign busy     = r_busy;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: default instance plus a FRAME_TICKS=4/GAP_TICKS=0 instance.
module tb_uart_tx_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        baud_tick;
  logic [3:0]  req, req6;
  logic [31:0] rd, rd6;
  logic [3:0]  ack, ack6;
  logic        tx_en, tx_en6;
  logic [7:0]  tx_data, tx_data6;
  logic [1:0]  grant_id, grant_id6;
  logic        busy, busy6;

  int total = 0;
  int bad   = 0;

  uart_tx_sched u_dut (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .req(req), .req_data(rd),
    .ack(ack), .tx_en(tx_en), .tx_data(tx_data), .grant_id(grant_id), .busy(busy)
  );

  uart_tx_sched #(.N_REQ(4), .FRAME_TICKS(4), .GAP_TICKS(0)) u_dut6 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .req(req6), .req_data(rd6),
    .ack(ack6), .tx_en(tx_en6), .tx_data(tx_data6), .grant_id(grant_id6), .busy(busy6)
  );

  always #5 clk = ~clk;

  // One-clk baud strobe every other cycle.
  initial begin
    baud_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1 baud_tick = ~baud_tick;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the negedge where an ack shows; cyc = negedges stepped.
  task automatic wait_ack(input int which, output int cyc);
    logic [3:0] a;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      a = (which == 0) ? ack : ack6;
    end while (a == 4'd0 && cyc < 2000);
    chk("ack_arrives", 32'(a != 4'd0), 32'd1);
  endtask

  // From a busy negedge, walk to the first idle negedge, recording ticks and stray pulses.
  task automatic measure(input int which, output int ticks, output int late_en,
                         output int late_ack, output int data_chg);
    logic       first;
    logic [7:0] d0;
    int         cyc;
    ticks = 0; late_en = 0; late_ack = 0; data_chg = 0; cyc = 0; first = 1'b1;
    d0 = (which == 0) ? tx_data : tx_data6;
    while (((which == 0) ? busy : busy6) && cyc < 4000) begin
      if (baud_tick) ticks++;
      if (!first && ((which == 0) ? tx_en : tx_en6)) late_en++;
      if (!first && ((which == 0) ? ack : ack6) != 4'd0) late_ack++;
      if (((which == 0) ? tx_data : tx_data6) != d0) data_chg++;
      first = 1'b0;
      cyc++;
      @(negedge clk);
    end
  endtask

  int cyc, ticks, le, la, dc;
  int exp_g4[4];

  initial begin
    rst = 1'b1; req = '0; req6 = '0; rd = '0; rd6 = '0;
    repeat (3) @(negedge clk);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_tx_en", 32'(tx_en), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_no_ack", 32'(ack), 32'd0);

    // Single request from requester 2.
    req = 4'b0100; rd[23:16] = 8'hA5;
    wait_ack(0, cyc);
    chk("t2_latency", 32'(cyc), 32'd1);
    chk("t2_ack", 32'(ack), 32'h4);
    chk("t2_tx_en", 32'(tx_en), 32'd1);
    chk("t2_tx_data", 32'(tx_data), 32'hA5);
    chk("t2_grant_id", 32'(grant_id), 32'd2);
    chk("t2_busy", 32'(busy), 32'd1);
    req = '0;
    measure(0, ticks, le, la, dc);
    chk("t2_busy_ticks", 32'(ticks), 32'd176);
    chk("t2_tx_en_once", 32'(le), 32'd0);
    chk("t2_data_stable", 32'(dc), 32'd0);
    chk("t2_data_after", 32'(tx_data), 32'hA5);

    // Reset in the middle of SEND.
    req = 4'b0010; rd[15:8] = 8'h3C;
    wait_ack(0, cyc);
    chk("t1_grant_id", 32'(grant_id), 32'd1);
    req = '0;
    ticks = 0;
    for (int i = 0; i < 1000 && ticks < 80; i++) begin
      if (baud_tick) ticks++;
      @(negedge clk);
    end
    chk("t1_mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t1_busy", 32'(busy), 32'd0);
    chk("t1_tx_en", 32'(tx_en), 32'd0);
    chk("t1_tx_data", 32'(tx_data), 32'd0);
    chk("t1_ack", 32'(ack), 32'd0);
    chk("t1_grant_id", 32'(grant_id), 32'd0);
    req = 4'b1000; rd[31:24] = 8'h77;
    wait_ack(0, cyc);
    chk("t1_new_ack", 32'(ack), 32'h8);
    chk("t1_new_data", 32'(tx_data), 32'h77);
    req = '0;
    measure(0, ticks, le, la, dc);
    chk("t1_new_ticks", 32'(ticks), 32'd176);

    // All four requesting continuously; pointer starts at 0.
    req = 4'b1111; rd = {8'h13, 8'h12, 8'h11, 8'h10};
    for (int i = 0; i < 5; i++) begin
      wait_ack(0, cyc);
      if (i > 0) chk("t3_arb_gap", 32'(cyc), 32'd1);
      chk("t3_grant_id", 32'(grant_id), 32'(i % 4));
      chk("t3_ack", 32'(ack), 32'(4'b0001 << (i % 4)));
      chk("t3_tx_data", 32'(tx_data), 32'(8'h10 + (i % 4)));
      if (i == 4) req = '0;
      measure(0, ticks, le, la, dc);
      chk("t3_ticks", 32'(ticks), 32'd176);
      chk("t3_no_extra_ack", 32'(la), 32'd0);
    end

    // Requester 3 alone brings the pointer back to 0.
    req = 4'b1000; rd[31:24] = 8'h33;
    wait_ack(0, cyc);
    chk("br_grant_id", 32'(grant_id), 32'd3);
    req = '0;
    measure(0, ticks, le, la, dc);

    // Mask 1011 held.
`ifdef UART_TX_SCHED_FIXED_PRIO_EN
    exp_g4 = '{0, 0, 0, 0};
`else
    exp_g4 = '{0, 1, 3, 0};
`endif
    req = 4'b1011; rd = {8'h43, 8'h42, 8'h41, 8'h40};
    for (int i = 0; i < 4; i++) begin
      wait_ack(0, cyc);
      chk("t4_grant_id", 32'(grant_id), 32'(exp_g4[i]));
      chk("t4_tx_data", 32'(tx_data), 32'(8'h40 + exp_g4[i]));
      if (i == 3) req = '0;
      measure(0, ticks, le, la, dc);
    end

    // Late request waits for GAP to end; a withdrawn pulse is never acked.
    req = 4'b1000; rd = {8'h93, 8'h00, 8'h5A, 8'hEE};
    wait_ack(0, cyc);
    chk("t5_first_id", 32'(grant_id), 32'd3);
    req = '0;
    repeat (2) @(negedge clk);
    req = 4'b0011;
    repeat (3) @(negedge clk);
    req = 4'b0010;
    measure(0, ticks, le, la, dc);
    chk("t5_no_ack_busy", 32'(la), 32'd0);
    chk("t5_idle_seen", 32'(busy), 32'd0);
    wait_ack(0, cyc);
    chk("t5_first_idle", 32'(cyc), 32'd1);
    chk("t5_ack", 32'(ack), 32'h2);
    chk("t5_tx_data", 32'(tx_data), 32'h5A);
    req = '0;
    measure(0, ticks, le, la, dc);
    chk("t5_no_stray_ack", 32'(la), 32'd0);

    // Short frame, no gap.
    req6 = 4'b0001; rd6[7:0] = 8'hC3;
    for (int i = 0; i < 3; i++) begin
      wait_ack(1, cyc);
      chk("t6_period", 32'(cyc), 32'd1);
      chk("t6_tx_en", 32'(tx_en6), 32'd1);
      chk("t6_tx_data", 32'(tx_data6), 32'hC3);
      if (i == 2) req6 = '0;
      measure(1, ticks, le, la, dc);
      chk("t6_ticks", 32'(ticks), 32'd4);
      chk("t6_tx_en_once", 32'(le), 32'd0);
    end
    repeat (4) @(negedge clk);
    chk("t6_idle_after", 32'(busy6), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
